batch_recursion: RTL
====================

# batch_recursion

Multi-channel backward-recursion batch estimator for the control-bounded filter datapath. It buffers control-bit vectors into ping-pong batches of `DEPTH` samples. Each completed batch is replayed newest-to-oldest through a single complex fixed-point recursion, w = λ·w + Σ ±F_n, and the real part is emitted once per cycle. It generalises the single-channel LUT-plus-recursion pair with per-channel coefficients, parametrised width and batch depth, input/output valid handshakes, and batch-local (reset-per-batch) backward recursion.

## Interface
- `N`, 3: number of control-bit channels.
- `DEPTH`, 32: samples per batch; power of two, ≥ 2.
- `WIDTH`, 32: signed two's-complement datapath width, all values Q(WIDTH-FRAC).FRAC.
- `FRAC`, 16: fractional bits.
- `LAMBDA_RE`, `LAMBDA_IM`, 32'h0000_8000 / 0: recursion factor λ, signed WIDTH-bit.
- `F_RE`, `F_IM`, {N{32'h0001_0000}} / 0: packed N*WIDTH vectors; channel n coefficient at bits [n*WIDTH +: WIDTH].

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in`  in  N  control bits of one sample; bit n=1 → +F_n, 0 → −F_n.
- `in_valid`  in  1  sample accepted on any rising edge with `in_valid`=1; no backpressure.
- `out`  out  WIDTH  Re(w) after the update for the current sample.
- `out_valid`  out  1  `out` holds a new estimate this cycle.
- `out_last`  out  1  with `out_valid`: estimate belongs to the batch's oldest sample (index 0).

## Operation
- Buffer: two banks of DEPTH×N bits. The write pointer `wr_ptr` counts 0..DEPTH-1 and writes `in` to bank `wr_bank`. On the write at index DEPTH-1, `wr_ptr` wraps to 0, `wr_bank` toggles, and a start request is raised for the filled bank.
- Engine FSM: IDLE, RUN.
  - IDLE → RUN on start request. `rd_ptr` loads DEPTH-1, `w` clears to 0+0i, and the bank is latched.
  - RUN: issues one read per cycle, `rd_ptr` decrements. After issuing index 0, returns to IDLE unless a start request is present in that same cycle. In that case it reloads directly, with no bubble.
- Data path per read sample s_k:
  - `c` = Σ_n (bit_n ? F_n : −F_n), real and imaginary, WIDTH-bit wrapping sum.
  - re' = ((λr·wr − λi·wi) >>> FRAC) + c_r.
  - im' = ((λr·wi + λi·wr) >>> FRAC) + c_i.
  - Products are full 2·WIDTH. The sum is formed at 2·WIDTH+1, then arithmetic-shifted (floor), then truncated to WIDTH (wrap, no saturation).
  - `out` ← re' and `out_valid` ← 1. `out_last` ← 1 when k = 0.
- Each batch starts from w = 0. No state carries between batches.
- Overrun is impossible by construction: a batch needs ≥ DEPTH accept edges, and the engine consumes exactly DEPTH cycles.
- Reset mid-operation: the partial batch and the in-flight batch are discarded. `wr_ptr`=0, `wr_bank`=0, FSM IDLE, w=0.

## Timing
- Reset values: `out`=0, `out_valid`=0, `out_last`=0. Buffer contents are don't-care.
- Edge E0 accepts the batch's last sample. E1 enters RUN and registers address DEPTH-1. E2 registers the read data. E3 registers the recursion result. `out_valid` is high from after E3 for DEPTH consecutive cycles, in order k = DEPTH-1 … 0.
- Latency is 3 edges from the last-sample accept to the first estimate.
- The recursion loop (λ·w + c → w) closes in one cycle.
- Continuous `in_valid`: batch b+1 completes at E0+DEPTH. Its first output follows the last output of batch b with no gap, and `out_valid` never drops.
- Gaps in `in_valid` only delay batch completion. Output bursts are always DEPTH cycles contiguous.
- Writes to the filling bank never touch the bank being read. The toggle happens on the same edge the engine latches the bank.

## Test plan
- N=1, DEPTH=4, λ=0.5, F0=1.0, `in` all 1 → outputs 0x10000, 0x18000, 0x1C000, 0x1E000; `out_last` only on the 4th; first `out_valid` 3 edges after the 4th accept.
- Same configuration, samples k0..k3 = 1,0,1,0 → outputs 0xFFFF0000, 0x00008000, 0xFFFF4000, 0x0000A000.
- λ = 0+1.0i, F0=1.0, all 1 → outputs 0x10000, 0x10000, 0, 0 (checks the complex cross terms).
- `in_valid` held high for 3·DEPTH samples with alternating batch patterns → `out_valid` continuous for 3·DEPTH cycles once started; each batch matches the reference model from w=0.
- Random `in_valid` gaps (≈50% duty) with N=3 and random bits → output stream matches the golden model and each burst is exactly DEPTH contiguous cycles.
- `rst` low for 1 cycle at `wr_ptr`=2 while outputs are active → outputs return to 0 and `out_valid` goes low immediately. No output appears until DEPTH new samples are accepted, and that batch is correct.

Source files
------------

// File: rtl/batch_recursion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | batch_recursion                                                          |
// | Ping-pong batch buffer + newest-to-oldest complex recursion w=lw+sum(+-F)|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module batch_recursion #(
  parameter int                   N         = 3,
  parameter int                   DEPTH     = 32,
  parameter int                   WIDTH     = 32,
  parameter int                   FRAC      = 16,
  parameter logic [WIDTH-1:0]     LAMBDA_RE = 32'h0000_8000,
  parameter logic [WIDTH-1:0]     LAMBDA_IM = 32'h0000_0000,
  parameter logic [N*WIDTH-1:0]   F_RE      = {N{32'h0001_0000}},
  parameter logic [N*WIDTH-1:0]   F_IM      = {N{32'h0000_0000}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int                      c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw-1:0]         c_last = c_aw'(DEPTH - 1);
  localparam logic signed [WIDTH-1:0] c_lre  = LAMBDA_RE;
  localparam logic signed [WIDTH-1:0] c_lim  = LAMBDA_IM;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [N-1:0]            r_mem [2][DEPTH];
  logic [c_aw-1:0]         r_wr_ptr;
  logic                    r_wr_bank;
  logic                    r_req;
  logic                    r_req_bank;

  state_t                  r_state;
  logic [c_aw-1:0]         r_rd_ptr;
  logic                    r_rd_bank;
  logic [N-1:0]            r_rd_data;
  logic                    r_rd_vld;
  logic                    r_rd_first;
  logic                    r_rd_last;

  logic signed [WIDTH-1:0] r_w_re;
  logic signed [WIDTH-1:0] r_w_im;

  logic signed [WIDTH-1:0]   w_wr;
  logic signed [WIDTH-1:0]   w_wi;
  logic signed [WIDTH-1:0]   w_c_re;
  logic signed [WIDTH-1:0]   w_c_im;
  logic signed [2*WIDTH-1:0] w_p_rr;
  logic signed [2*WIDTH-1:0] w_p_ii;
  logic signed [2*WIDTH-1:0] w_p_ri;
  logic signed [2*WIDTH-1:0] w_p_ir;
  logic signed [2*WIDTH:0]   w_sum_re;
  logic signed [2*WIDTH:0]   w_sum_im;
  logic signed [WIDTH-1:0]   w_nxt_re;
  logic signed [WIDTH-1:0]   w_nxt_im;

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_mem[r_wr_bank][r_wr_ptr] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_wr_bank  <= 1'b0;
      r_req      <= 1'b0;
      r_req_bank <= 1'b0;
    end else begin
      r_req <= 1'b0;
      if (in_valid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == c_last) begin
          r_wr_bank  <= ~r_wr_bank;
          r_req      <= 1'b1;
          r_req_bank <= r_wr_bank;
        end
      end
    end
  end

  // A new request can only coincide with the final read of the previous batch,
  // so reloading there gives gap-free replay under continuous input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_rd_bank  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_vld   <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_req) begin
            r_state   <= S_RUN;
            r_rd_ptr  <= c_last;
            r_rd_bank <= r_req_bank;
          end
        end
        S_RUN: begin
          r_rd_data  <= r_mem[r_rd_bank][r_rd_ptr];
          r_rd_vld   <= 1'b1;
          r_rd_first <= (r_rd_ptr == c_last);
          r_rd_last  <= (r_rd_ptr == '0);
          r_rd_ptr   <= r_rd_ptr - 1'b1;
          if (r_rd_ptr == '0) begin
            if (r_req) begin
              r_rd_ptr  <= c_last;
              r_rd_bank <= r_req_bank;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Batch-local recursion: the first sample of a batch sees w = 0.
  always_comb begin
    w_wr   = r_rd_first ? '0 : r_w_re;
    w_wi   = r_rd_first ? '0 : r_w_im;
    w_c_re = '0;
    w_c_im = '0;
    for (int n = 0; n < N; n++) begin
      if (r_rd_data[n]) begin
        w_c_re = w_c_re + F_RE[n*WIDTH +: WIDTH];
        w_c_im = w_c_im + F_IM[n*WIDTH +: WIDTH];
      end else begin
        w_c_re = w_c_re - F_RE[n*WIDTH +: WIDTH];
        w_c_im = w_c_im - F_IM[n*WIDTH +: WIDTH];
      end
    end
    w_p_rr   = c_lre * w_wr;
    w_p_ii   = c_lim * w_wi;
    w_p_ri   = c_lre * w_wi;
    w_p_ir   = c_lim * w_wr;
    w_sum_re = $signed({w_p_rr[2*WIDTH-1], w_p_rr}) - $signed({w_p_ii[2*WIDTH-1], w_p_ii});
    w_sum_im = $signed({w_p_ri[2*WIDTH-1], w_p_ri}) + $signed({w_p_ir[2*WIDTH-1], w_p_ir});
    w_nxt_re = WIDTH'(w_sum_re >>> FRAC) + w_c_re;
    w_nxt_im = WIDTH'(w_sum_im >>> FRAC) + w_c_im;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_re    <= '0;
      r_w_im    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= r_rd_vld;
      out_last  <= r_rd_vld & r_rd_last;
      if (r_rd_vld) begin
        r_w_re <= w_nxt_re;
        r_w_im <= w_nxt_im;
        out    <= w_nxt_re;
      end
    end
  end

endmodule
`default_nettype wire
